// File: rtl/ppc_types_pkg.sv
// Shared types for the trap path: decoded TO field and reservation-station entries.
package ppc_types;

    // Decoded TO field of tw/twi. Bit order follows TO[0..4]: lt, gt, eq, ltu, gtu.
    typedef struct packed {
        logic lt;
        logic gt;
        logic eq;
        logic ltu;
        logic gtu;
    } trap_decode_t;

    typedef enum logic [1:0] {
        RS_FREE    = 2'd0,
        RS_WAITING = 2'd1,
        RS_ISSUED  = 2'd2
    } rs_entry_state_t;

    // Tags are stored at this fixed width; station ID widths up to this are supported.
    localparam int RS_TAG_MAX_W = 8;

    typedef struct packed {
        rs_entry_state_t         state;
        logic                    op1_valid;
        logic                    op2_valid;
        logic [31:0]             op1_value;
        logic [31:0]             op2_value;
        logic [RS_TAG_MAX_W-1:0] op1_tag;
        logic [RS_TAG_MAX_W-1:0] op2_tag;
        trap_decode_t            control;
    } trap_rs_entry_t;

    localparam trap_rs_entry_t RS_ENTRY_RESET = '{
        state:     RS_FREE,
        op1_valid: 1'b0,
        op2_valid: 1'b0,
        op1_value: 32'd0,
        op2_value: 32'd0,
        op1_tag:   '0,
        op2_tag:   '0,
        control:   '0
    };

endpackage

// File: rtl/trap_reservation_station_rs_priority_select.sv
// Lowest-index set-bit finder: one-hot grant, binary index and any-set flag.
module rs_priority_select #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic [WIDTH-1:0] i_req,
    output logic [WIDTH-1:0] o_onehot,
    output logic [IDX_W-1:0] o_index,
    output logic             o_any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_onehot = '0;
        o_index  = '0;
        o_any    = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_index     = IDX_W'(i);
                o_any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trap_reservation_station.sv
// Reservation station feeding the trap unit. Entries wait for operands (from
// dispatch or CDB snoop), issue through a one-deep registered slot, and hold
// their ID until the trap unit hands it back on release.
module trap_reservation_station
    import ppc_types::*;
#(
    parameter int ENTRIES     = 4,
    parameter int RS_ID_WIDTH = 5,
    parameter int RS_OFFSET   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   dispatch_valid,
    output logic                   dispatch_ready,
    input  logic                   dispatch_op1_valid,
    input  logic [31:0]            dispatch_op1_value,
    input  logic [RS_ID_WIDTH-1:0] dispatch_op1_tag,
    input  logic                   dispatch_op2_valid,
    input  logic [31:0]            dispatch_op2_value,
    input  logic [RS_ID_WIDTH-1:0] dispatch_op2_tag,
    input  trap_decode_t           dispatch_control,
    output logic [RS_ID_WIDTH-1:0] dispatch_rs_id,
    input  logic                   cdb_valid,
    input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
    input  logic [31:0]            cdb_value,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [RS_ID_WIDTH-1:0] issue_rs_id,
    output logic [31:0]            issue_op1,
    output logic [31:0]            issue_op2,
    output trap_decode_t           issue_control,
    input  logic                   release_valid,
    input  logic [RS_ID_WIDTH-1:0] release_rs_id
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    trap_rs_entry_t r_entry     [ENTRIES];
    trap_rs_entry_t w_entry_nxt [ENTRIES];
    trap_rs_entry_t w_disp_entry;
    trap_rs_entry_t w_iss_entry;

    logic [ENTRIES-1:0][RS_ID_WIDTH-1:0] w_entry_id;
    logic [ENTRIES-1:0] w_free;
    logic [ENTRIES-1:0] w_ready;
    logic [ENTRIES-1:0] w_rel_hit;
    logic [ENTRIES-1:0] w_alloc_oh;
    logic [ENTRIES-1:0] w_iss_oh;
    logic [IDX_W-1:0]   w_alloc_idx;
    logic [IDX_W-1:0]   w_iss_idx;
    logic               w_alloc_any;
    logic               w_iss_any;
    logic               w_disp_fire;
    logic               w_slot_open;
    logic               w_load;
    logic [RS_TAG_MAX_W-1:0] w_cdb_tag;

    logic                   r_issue_valid;
    logic [RS_ID_WIDTH-1:0] r_issue_rs_id;
    logic [31:0]            r_issue_op1;
    logic [31:0]            r_issue_op2;
    trap_decode_t           r_issue_control;

    assign w_cdb_tag = RS_TAG_MAX_W'(cdb_rs_id);

    // Per-entry status decoded from registered state only.
    for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
        assign w_entry_id[g] = RS_ID_WIDTH'(RS_OFFSET + g);
        assign w_free[g]     = (r_entry[g].state == RS_FREE);
        assign w_ready[g]    = (r_entry[g].state == RS_WAITING) &&
                               r_entry[g].op1_valid && r_entry[g].op2_valid;
        assign w_rel_hit[g]  = release_valid && (release_rs_id == w_entry_id[g]) &&
                               (r_entry[g].state == RS_ISSUED);
    end

    rs_priority_select #(.WIDTH(ENTRIES), .IDX_W(IDX_W)) u_alloc_sel (
        .i_req    (w_free),
        .o_onehot (w_alloc_oh),
        .o_index  (w_alloc_idx),
        .o_any    (w_alloc_any)
    );

    rs_priority_select #(.WIDTH(ENTRIES), .IDX_W(IDX_W)) u_issue_sel (
        .i_req    (w_ready),
        .o_onehot (w_iss_oh),
        .o_index  (w_iss_idx),
        .o_any    (w_iss_any)
    );

    assign dispatch_ready = w_alloc_any;
    assign dispatch_rs_id = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(w_alloc_idx);
    assign w_disp_fire    = dispatch_valid && w_alloc_any;
    assign w_slot_open    = !r_issue_valid || issue_ready;
    assign w_load         = w_slot_open && w_iss_any;

    // New entry image; a same-cycle CDB broadcast fills a missing operand.
    always_comb begin
        w_disp_entry         = RS_ENTRY_RESET;
        w_disp_entry.state   = RS_WAITING;
        w_disp_entry.op1_tag = RS_TAG_MAX_W'(dispatch_op1_tag);
        w_disp_entry.op2_tag = RS_TAG_MAX_W'(dispatch_op2_tag);
        w_disp_entry.control = dispatch_control;
        if (dispatch_op1_valid) begin
            w_disp_entry.op1_valid = 1'b1;
            w_disp_entry.op1_value = dispatch_op1_value;
        end else if (cdb_valid && (cdb_rs_id == dispatch_op1_tag)) begin
            w_disp_entry.op1_valid = 1'b1;
            w_disp_entry.op1_value = cdb_value;
        end
        if (dispatch_op2_valid) begin
            w_disp_entry.op2_valid = 1'b1;
            w_disp_entry.op2_value = dispatch_op2_value;
        end else if (cdb_valid && (cdb_rs_id == dispatch_op2_tag)) begin
            w_disp_entry.op2_valid = 1'b1;
            w_disp_entry.op2_value = cdb_value;
        end
    end

    // Entry FSM next state. Dispatch, issue-load and release act on entries in
    // different states, so they never collide on one entry.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            w_entry_nxt[i] = r_entry[i];
            if (flush) begin
                w_entry_nxt[i].state = RS_FREE;
            end else begin
                case (r_entry[i].state)
                    RS_FREE: begin
                        if (w_disp_fire && w_alloc_oh[i])
                            w_entry_nxt[i] = w_disp_entry;
                    end
                    RS_WAITING: begin
                        if (w_load && w_iss_oh[i]) begin
                            w_entry_nxt[i].state = RS_ISSUED;
                        end else if (cdb_valid) begin
                            if (!r_entry[i].op1_valid && (r_entry[i].op1_tag == w_cdb_tag)) begin
                                w_entry_nxt[i].op1_valid = 1'b1;
                                w_entry_nxt[i].op1_value = cdb_value;
                            end
                            if (!r_entry[i].op2_valid && (r_entry[i].op2_tag == w_cdb_tag)) begin
                                w_entry_nxt[i].op2_valid = 1'b1;
                                w_entry_nxt[i].op2_value = cdb_value;
                            end
                        end
                    end
                    RS_ISSUED: begin
                        if (w_rel_hit[i])
                            w_entry_nxt[i].state = RS_FREE;
                    end
                    default: w_entry_nxt[i] = RS_ENTRY_RESET;
                endcase
            end
        end
    end

    // Entry state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) r_entry[i] <= RS_ENTRY_RESET;
        end else begin
            for (int i = 0; i < ENTRIES; i++) r_entry[i] <= w_entry_nxt[i];
        end
    end

    // Mux the selected ready entry toward the issue slot.
    always_comb begin
        w_iss_entry = RS_ENTRY_RESET;
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_iss_oh[i]) w_iss_entry = r_entry[i];
        end
    end

    // Issue slot: refills when empty or consumed, otherwise holds steady.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue_valid   <= 1'b0;
            r_issue_rs_id   <= '0;
            r_issue_op1     <= 32'd0;
            r_issue_op2     <= 32'd0;
            r_issue_control <= '0;
        end else if (flush) begin
            r_issue_valid <= 1'b0;
        end else if (w_slot_open) begin
            r_issue_valid <= w_iss_any;
            if (w_iss_any) begin
                r_issue_rs_id   <= RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(w_iss_idx);
                r_issue_op1     <= w_iss_entry.op1_value;
                r_issue_op2     <= w_iss_entry.op2_value;
                r_issue_control <= w_iss_entry.control;
            end
        end
    end

    assign issue_valid   = r_issue_valid;
    assign issue_rs_id   = r_issue_rs_id;
    assign issue_op1     = r_issue_op1;
    assign issue_op2     = r_issue_op2;
    assign issue_control = r_issue_control;

endmodule

// File: tb/tb_trap_reservation_station.sv
// Bench for trap_reservation_station: vector table, directed corner sequences,
// then random traffic against an entry-level reference model.
module tb_trap_reservation_station;
    import ppc_types::*;

    localparam int ENT = 4, IDW = 5, OFF = 0;
    localparam int M_FREE = 0, M_WAIT = 1, M_ISS = 2;

    logic clk = 1'b0;
    logic rst, flush, dispatch_valid, dispatch_ready;
    logic dispatch_op1_valid, dispatch_op2_valid;
    logic [31:0] dispatch_op1_value, dispatch_op2_value, cdb_value, issue_op1, issue_op2;
    logic [IDW-1:0] dispatch_op1_tag, dispatch_op2_tag, dispatch_rs_id, cdb_rs_id;
    logic [IDW-1:0] issue_rs_id, release_rs_id;
    logic cdb_valid, issue_valid, issue_ready, release_valid;
    trap_decode_t dispatch_control, issue_control;

    always #5 clk = ~clk;

    trap_reservation_station #(.ENTRIES(ENT), .RS_ID_WIDTH(IDW), .RS_OFFSET(OFF)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_op1_valid(dispatch_op1_valid), .dispatch_op1_value(dispatch_op1_value),
        .dispatch_op1_tag(dispatch_op1_tag),
        .dispatch_op2_valid(dispatch_op2_valid), .dispatch_op2_value(dispatch_op2_value),
        .dispatch_op2_tag(dispatch_op2_tag),
        .dispatch_control(dispatch_control), .dispatch_rs_id(dispatch_rs_id),
        .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rs_id(issue_rs_id),
        .issue_op1(issue_op1), .issue_op2(issue_op2), .issue_control(issue_control),
        .release_valid(release_valid), .release_rs_id(release_rs_id)
    );

    int n_checks = 0, n_fail = 0;

    // Reference model: what each entry holds and what sits in the issue slot.
    int          m_st  [ENT];
    bit          m_v1  [ENT], m_v2 [ENT];
    logic [31:0] m_o1  [ENT], m_o2 [ENT];
    logic [4:0]  m_t1  [ENT], m_t2 [ENT], m_ctl [ENT];
    bit          m_sv;
    int          m_sid;
    logic [31:0] m_so1, m_so2;
    logic [4:0]  m_sctl;
    bit          m_hs;
    int          m_hs_id;
    bit          stray_ok;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENT; i++) begin
            m_st[i] = M_FREE; m_v1[i] = 0; m_v2[i] = 0;
        end
        m_sv = 0; m_hs = 0;
    endtask

    // One clock edge of the station, from the rules: flush wins; otherwise snoop,
    // slot refill from the oldest-index ready entry, release, and allocation.
    task automatic model_edge();
        int rdy, fre, rid;
        m_hs = 0;
        if (flush) begin
            for (int i = 0; i < ENT; i++) m_st[i] = M_FREE;
            m_sv = 0;
            return;
        end
        rdy = -1; fre = -1;
        for (int i = 0; i < ENT; i++) begin
            if (rdy < 0 && m_st[i] == M_WAIT && m_v1[i] && m_v2[i]) rdy = i;
            if (fre < 0 && m_st[i] == M_FREE) fre = i;
        end
        for (int i = 0; i < ENT; i++) begin
            if (m_st[i] == M_WAIT && cdb_valid) begin
                if (!m_v1[i] && m_t1[i] == cdb_rs_id) begin m_v1[i] = 1; m_o1[i] = cdb_value; end
                if (!m_v2[i] && m_t2[i] == cdb_rs_id) begin m_v2[i] = 1; m_o2[i] = cdb_value; end
            end
        end
        if (!m_sv || issue_ready) begin
            if (m_sv) begin m_hs = 1; m_hs_id = m_sid; end
            m_sv = (rdy >= 0);
            if (rdy >= 0) begin
                m_sid = OFF + rdy; m_so1 = m_o1[rdy]; m_so2 = m_o2[rdy]; m_sctl = m_ctl[rdy];
                m_st[rdy] = M_ISS;
            end
        end
        rid = int'(release_rs_id) - OFF;
        if (release_valid && rid >= 0 && rid < ENT) begin
            if (m_st[rid] == M_ISS) m_st[rid] = M_FREE;
        end
        if (dispatch_valid && fre >= 0) begin
            m_st[fre] = M_WAIT;
            m_t1[fre] = dispatch_op1_tag; m_t2[fre] = dispatch_op2_tag; m_ctl[fre] = dispatch_control;
            m_v1[fre] = dispatch_op1_valid || (cdb_valid && cdb_rs_id == dispatch_op1_tag);
            m_o1[fre] = dispatch_op1_valid ? dispatch_op1_value : cdb_value;
            m_v2[fre] = dispatch_op2_valid || (cdb_valid && cdb_rs_id == dispatch_op2_tag);
            m_o2[fre] = dispatch_op2_valid ? dispatch_op2_value : cdb_value;
        end
    endtask

    task automatic model_check();
        int fre = -1;
        for (int i = ENT - 1; i >= 0; i--) if (m_st[i] == M_FREE) fre = i;
        chk("dispatch_ready", 32'(dispatch_ready), 32'(fre >= 0));
        if (fre >= 0) chk("dispatch_rs_id", 32'(dispatch_rs_id), OFF + fre);
        chk("issue_valid", 32'(issue_valid), 32'(m_sv));
        if (m_sv) begin
            chk("issue_rs_id", 32'(issue_rs_id), m_sid);
            chk("issue_op1", issue_op1, m_so1);
            chk("issue_op2", issue_op2, m_so2);
            chk("issue_control", 32'(issue_control), 32'(m_sctl));
        end
    endtask

    // Advance one clock: flag stray releases, step the model, check, clear pulses.
    task automatic step();
        int rid;
        bit hit;
        if (release_valid) begin
            rid = int'(release_rs_id) - OFF;
            hit = 0;
            if (rid >= 0 && rid < ENT) hit = (m_st[rid] == M_ISS);
            chk("release_matches_issued", 32'(hit), 32'(!stray_ok));
        end
        model_edge();
        @(posedge clk); #1;
        model_check();
        dispatch_valid = 0; cdb_valid = 0; release_valid = 0; flush = 0; stray_ok = 0;
    endtask

    task automatic disp(input bit v1, input logic [31:0] o1, input logic [4:0] t1,
                        input bit v2, input logic [31:0] o2, input logic [4:0] t2,
                        input logic [4:0] ctl);
        dispatch_valid = 1;
        dispatch_op1_valid = v1; dispatch_op1_value = o1; dispatch_op1_tag = t1;
        dispatch_op2_valid = v2; dispatch_op2_value = o2; dispatch_op2_tag = t2;
        dispatch_control = ctl;
    endtask

    task automatic rel(input logic [4:0] id, input bit stray);
        release_valid = 1; release_rs_id = id; stray_ok = stray;
    endtask

    typedef struct {
        bit o1v; logic [31:0] o1; logic [4:0] t1;
        bit o2v; logic [31:0] o2; logic [4:0] t2;
        logic [4:0] ctl;
        bit cv; logic [4:0] cid; logic [31:0] cval;
        int late_k; logic [4:0] late_id; logic [31:0] late_val;
        int exp_lat; logic [31:0] e1, e2;
    } vec_t;
    vec_t tbl [5];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1, 32'd5, 5'd0, 1, 32'd5, 5'd0, 5'b00100, 0, 5'd0, 32'd0,
                   -1, 5'd0, 32'd0, 2, 32'd5, 32'd5};
        tbl[1] = '{0, 32'd0, 5'd7, 1, 32'd3, 5'd0, 5'b10000, 0, 5'd0, 32'd0,
                   2, 5'd7, 32'hFFFF_FFFF, 4, 32'hFFFF_FFFF, 32'd3};
        tbl[2] = '{1, 32'h20, 5'd9, 0, 32'd0, 5'd9, 5'b01000, 1, 5'd9, 32'h10,
                   -1, 5'd0, 32'd0, 2, 32'h20, 32'h10};
        tbl[3] = '{0, 32'd0, 5'd7, 0, 32'd0, 5'd7, 5'b00011, 0, 5'd0, 32'd0,
                   1, 5'd7, 32'hABCD, 3, 32'hABCD, 32'hABCD};
        tbl[4] = '{0, 32'd0, 5'd2, 1, 32'h8000_0000, 5'd0, 5'b11111, 1, 5'd3, 32'h55,
                   3, 5'd2, 32'h1234, 5, 32'h1234, 32'h8000_0000};

        rst = 0; flush = 0; dispatch_valid = 0; cdb_valid = 0; release_valid = 0;
        issue_ready = 1; stray_ok = 0;
        dispatch_op1_valid = 0; dispatch_op2_valid = 0; dispatch_op1_value = 0; dispatch_op2_value = 0;
        dispatch_op1_tag = 0; dispatch_op2_tag = 0; dispatch_control = '0;
        cdb_rs_id = 0; cdb_value = 0; release_rs_id = 0;
        model_reset();
        #1 rst = 1;
        #11;
        chk("rst_issue_valid", 32'(issue_valid), 0);
        chk("rst_issue_rs_id", 32'(issue_rs_id), 0);
        chk("rst_issue_op1", issue_op1, 0);
        chk("rst_issue_op2", issue_op2, 0);
        chk("rst_issue_control", 32'(issue_control), 0);
        chk("rst_dispatch_ready", 32'(dispatch_ready), 1);
        chk("rst_dispatch_rs_id", 32'(dispatch_rs_id), 0);
        @(negedge clk); rst = 0;
        @(posedge clk); #1;

        // Vector table: one instruction at a time through an empty station.
        for (int r = 0; r < 5; r++) begin
            int lat;
            logic [31:0] g1, g2, gc, gid;
            lat = -1; g1 = 0; g2 = 0; gc = 0; gid = 0;
            for (int k = 0; k < 10 && lat < 0; k++) begin
                if (k == 0) begin
                    disp(tbl[r].o1v, tbl[r].o1, tbl[r].t1, tbl[r].o2v, tbl[r].o2, tbl[r].t2, tbl[r].ctl);
                    if (tbl[r].cv) begin cdb_valid = 1; cdb_rs_id = tbl[r].cid; cdb_value = tbl[r].cval; end
                end
                if (k == tbl[r].late_k) begin
                    cdb_valid = 1; cdb_rs_id = tbl[r].late_id; cdb_value = tbl[r].late_val;
                end
                step();
                if (issue_valid) begin
                    lat = k + 1; g1 = issue_op1; g2 = issue_op2;
                    gc = 32'(issue_control); gid = 32'(issue_rs_id);
                end
            end
            chk("tbl_latency", lat, tbl[r].exp_lat);
            chk("tbl_rs_id", gid, 0);
            chk("tbl_op1", g1, tbl[r].e1);
            chk("tbl_op2", g2, tbl[r].e2);
            chk("tbl_control", gc, 32'(tbl[r].ctl));
            step();
            chk("tbl_held_until_release", 32'(dispatch_rs_id), 1);
            rel(5'd0, 0);
            step();
            chk("tbl_freed_by_release", 32'(dispatch_rs_id), 0);
        end

        // Fill all entries with the trap unit stalled.
        issue_ready = 0;
        for (int i = 0; i < ENT; i++) begin
            chk("fill_rs_id", 32'(dispatch_rs_id), i);
            disp(1, 100 + i, 5'd0, 1, 200 + i, 5'd0, 5'(i));
            step();
        end
        chk("full_not_ready", 32'(dispatch_ready), 0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_rs_id", 32'(issue_rs_id), 0);
            chk("stall_op1", issue_op1, 100);
            disp(1, 32'hDEAD, 5'd0, 1, 32'hBEEF, 5'd0, 5'd1);
            step();
        end
        issue_ready = 1;
        for (int i = 0; i < ENT; i++) begin
            chk("order_valid", 32'(issue_valid), 1);
            chk("order_rs_id", 32'(issue_rs_id), i);
            chk("order_op1", issue_op1, 100 + i);
            step();
        end
        chk("drained", 32'(issue_valid), 0);
        chk("no_free_before_release", 32'(dispatch_ready), 0);

        // Dispatch, issue-load and release on three different entries at once.
        rel(5'd0, 0); step();
        rel(5'd1, 0); step();
        issue_ready = 0;
        disp(1, 32'h200, 5'd0, 1, 32'h201, 5'd0, 5'b00100); step();
        chk("sim_pre_rs_id", 32'(dispatch_rs_id), 1);
        disp(1, 32'h300, 5'd0, 1, 32'h301, 5'd0, 5'b00010);
        rel(5'd2, 0);
        step();
        chk("sim_issue_rs_id", 32'(issue_rs_id), 0);
        chk("sim_issue_op1", issue_op1, 32'h200);
        chk("sim_alloc_after", 32'(dispatch_rs_id), 2);
        issue_ready = 1; step();
        chk("sim_next_issue", 32'(issue_rs_id), 1);
        chk("sim_next_op1", issue_op1, 32'h300);
        issue_ready = 0;

        // Stray releases: waiting entry, out-of-range IDs aliasing entry 0.
        disp(0, 32'd0, 5'd30, 1, 32'd7, 5'd0, 5'd0); step();
        chk("waiting_full", 32'(dispatch_ready), 0);
        rel(5'd2, 1); step();
        chk("stray_waiting_ignored", 32'(dispatch_ready), 0);
        rel(5'd4, 1); step();
        chk("stray_id4_ignored", 32'(dispatch_ready), 0);
        rel(5'd20, 1); step();
        chk("stray_id20_ignored", 32'(dispatch_ready), 0);

        // Flush with the slot full; a same-cycle dispatch must lose.
        chk("pre_flush_slot", 32'(issue_valid), 1);
        flush = 1;
        disp(1, 32'd1, 5'd0, 1, 32'd1, 5'd0, 5'd0);
        step();
        chk("flush_issue_valid", 32'(issue_valid), 0);
        chk("flush_dispatch_ready", 32'(dispatch_ready), 1);
        chk("flush_dispatch_rs_id", 32'(dispatch_rs_id), 0);

        // Async reset with three entries busy and the slot full.
        for (int i = 0; i < 3; i++) begin
            disp(1, 32'h40 + i, 5'd0, 1, 32'h50 + i, 5'd0, 5'd3);
            step();
        end
        chk("pre_rst_slot", 32'(issue_valid), 1);
        #2 rst = 1;
        #1;
        chk("arst_issue_valid", 32'(issue_valid), 0);
        chk("arst_issue_rs_id", 32'(issue_rs_id), 0);
        chk("arst_issue_op1", issue_op1, 0);
        chk("arst_issue_op2", issue_op2, 0);
        chk("arst_issue_control", 32'(issue_control), 0);
        chk("arst_dispatch_ready", 32'(dispatch_ready), 1);
        chk("arst_dispatch_rs_id", 32'(dispatch_rs_id), 0);
        model_reset();
        @(negedge clk); rst = 0;
        step();

        // Random traffic with an in-order trap unit model returning IDs.
        begin
            int pipe[$];
            bit fl;
            logic [4:0] ctl;
            for (int c = 0; c < 3000; c++) begin
                ctl = 5'($urandom);
                disp($urandom_range(0, 2) != 0, $urandom, 5'($urandom_range(0, 7)),
                     $urandom_range(0, 2) != 0, $urandom, 5'($urandom_range(0, 7)), ctl);
                dispatch_valid = $urandom_range(0, 1) != 0;
                cdb_valid = $urandom_range(0, 9) < 4;
                cdb_rs_id = 5'($urandom_range(0, 7));
                cdb_value = $urandom;
                issue_ready = $urandom_range(0, 3) != 0;
                if (pipe.size() > 0 && $urandom_range(0, 1) != 0) begin
                    rel(5'(pipe[0]), 0);
                    void'(pipe.pop_front());
                end
                flush = ($urandom_range(0, 199) == 0);
                fl = flush;
                step();
                if (fl) pipe.delete();
                if (m_hs) pipe.push_back(m_hs_id);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trap_reservation_station.md
Name: trap_reservation_station

Overview:
- Reservation station directly upstream of the trap unit. Holds trap instructions (tw/twi) from dispatch until both operands are available.
- Operands arrive either at dispatch or by snooping the common data bus (CDB). A ready entry issues to the trap unit through a registered valid/ready output slot.
- Each entry keeps its ID until the trap unit returns that ID with its result. This prevents ID aliasing while an instruction is inside the 2-stage trap pipeline.

Parameters:
- ENTRIES, 4, number of station entries (2..16).
- RS_ID_WIDTH, 5, width of station IDs and operand tags.
- RS_OFFSET, 0, ID of entry 0; entry i has ID RS_OFFSET+i.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- flush  input  1  synchronous clear of all entries and the issue slot
- dispatch_valid  input  1  dispatch request
- dispatch_ready  output  1  a free entry exists
- dispatch_op1_valid  input  1  op1 value already available
- dispatch_op1_value  input  32  op1 value
- dispatch_op1_tag  input  RS_ID_WIDTH  producer ID of op1 when not valid
- dispatch_op2_valid / dispatch_op2_value / dispatch_op2_tag  input  1/32/RS_ID_WIDTH  same for op2
- dispatch_control  input  trap_decode_t  decoded TO field
- dispatch_rs_id  output  RS_ID_WIDTH  ID of the entry to be allocated (valid when dispatch_ready)
- cdb_valid  input  1  result broadcast
- cdb_rs_id  input  RS_ID_WIDTH  producer ID of the broadcast
- cdb_value  input  32  broadcast value
- issue_valid  output  1  to trap unit input_valid
- issue_ready  input  1  from trap unit input_ready
- issue_rs_id  output  RS_ID_WIDTH  to trap unit rs_id_in
- issue_op1 / issue_op2  output  32  to trap unit op1/op2
- issue_control  output  trap_decode_t  to trap unit control
- release_valid  input  1  trap unit output handshake (output_valid & output_ready)
- release_rs_id  input  RS_ID_WIDTH  trap unit rs_id_out

Behaviour:
- Entry states: FREE -> WAITING (on dispatch) -> ISSUED (loaded into the issue slot) -> FREE (on release_valid with a matching ID).
- Reset/flush: all entries FREE, issue slot empty. Reset values: issue_valid=0, issue_rs_id=0, issue_op1=0, issue_op2=0, issue_control='0.
- flush has priority over every other event in the same cycle.
- dispatch_ready is 1 if any entry is FREE in the current registered state. A same-cycle release does not count.
- dispatch_rs_id is the lowest-index FREE entry.
- Dispatch handshake: dispatch_valid & dispatch_ready.
- Dispatch operand capture: if an operand is not valid, but cdb_valid is 1 and cdb_rs_id equals its tag in the same cycle, the entry stores cdb_value and marks the operand valid.
- CDB snoop on WAITING entries: every operand with a matching, not-yet-valid tag captures cdb_value. Multiple entries and both operands may capture in the same cycle.
- An entry is ready when it is WAITING and both operands are valid, using registered state (no CDB-to-issue bypass).
- Issue slot is one register stage. It loads the lowest-index ready entry when the slot is empty or when issue_ready & issue_valid.
  - That entry goes to ISSUED in the same cycle.
  - Latency: dispatch with both operands valid at cycle t -> issue_valid at t+2.
- issue_* outputs are stable while issue_valid=1 and issue_ready=0.
- Release: the entry whose ID matches release_rs_id goes ISSUED -> FREE.
  - A release with no matching ISSUED entry is ignored. A bench assertion must flag it.
  - A release ID outside [RS_OFFSET, RS_OFFSET+ENTRIES-1] is ignored.
- Simultaneous dispatch, issue-load and release must target distinct entries, and all three take effect in the same cycle.
- cdb_rs_id values outside this station's range are normal (other stations' producers).

Decomposition:
- Add rs_entry_state_t (FREE/WAITING/ISSUED) and trap_rs_entry_t (state, op valid bits, op values, tags, control) to ppc_types. trap_decode_t is already there.
- One natural sub-module: rs_priority_select, a parameterised lowest-index-set-bit finder returning a one-hot and an index. It is used for both allocation and issue selection.

Test Plan:
- Dispatch op1=5, op2=5 (both valid, TO=00100) into an empty station -> dispatch_rs_id=0 and issue_valid at t+2 with issue_rs_id=0, op1=op2=5. After the trap unit release, entry 0 is FREE again.
- Dispatch with op1 tag=7 not valid, then cdb_valid with rs_id=7, value=0xFFFFFFFF two cycles later -> issue_op1=0xFFFFFFFF, issue two cycles after the broadcast.
- Dispatch with op2 tag=9 while the CDB broadcasts ID 9, value 0x10 in the same cycle -> operand captured; issue_op2=0x10.
- Fill all 4 entries with issue_ready held at 0 -> dispatch_ready=0; issue_rs_id stays 0 with stable outputs. Then issue_ready=1 -> IDs issue in order 0,1,2,3. Entries do not free until release.
- Dispatch, issue-load and release of different entries in one cycle -> all three take effect with no ID reuse in flight.
- Assert flush (and separately async rst) with 3 entries busy and the slot full -> next cycle issue_valid=0, dispatch_ready=1, dispatch_rs_id=0.
